// File: rtl/uart_boot_ctrl.sv
// Boot-load sequencer: parses A5/length/payload/checksum frames from uart_rx,
// writes little-endian words to consecutive memory addresses and holds the CPU until a frame checks out.
module uart_boot_ctrl #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       MAX_WORDS = 1024,
   parameter int unsigned       TIMEOUT   = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_end,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              boot_done,
   output logic              boot_err
);
   // state | meaning
   // IDLE  | no frame seen since reset, waiting for 0xA5
   // LEN0  | expecting word-count low byte
   // LEN1  | expecting word-count high byte
   // DATA  | collecting payload bytes, one write per 4 bytes
   // CSUM  | expecting checksum byte
   // DONE  | frame loaded and verified, CPU released
   // ERR   | frame aborted, CPU held
   localparam int unsigned WIDX_W = $clog2(MAX_WORDS + 1);
   localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
   state_t state, state_next;

   logic [7:0]        len_lo;
   logic [15:0]       len;
   logic [15:0]       len_rx;
   logic [7:0]        csum;
   logic [1:0]        byte_idx;
   logic [WIDX_W-1:0] word_idx;
   logic [23:0]       word_buf;
   logic [TMR_W-1:0]  tmr;
   logic              in_frame;
   logic              timeout_hit;
   logic              word_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      len_rx      = {rx_data, len_lo};
      in_frame    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
      // a byte arriving on the terminal cycle keeps the frame alive
      timeout_hit = in_frame && !rx_end && (tmr == TMR_W'(TIMEOUT - 1));
      word_last   = (32'(word_idx) + 32'd1) == 32'(len);
      case (state)
         IDLE, DONE, ERR: if (rx_end && rx_data == 8'hA5) state_next = LEN0;
         LEN0: if (rx_end) state_next = LEN1;
         LEN1: begin
            if (rx_end) begin
               if (32'(len_rx) > MAX_WORDS) state_next = ERR;
               else if (len_rx == 16'd0)    state_next = CSUM;
               else                         state_next = DATA;
            end
         end
         DATA: if (rx_end && byte_idx == 2'd3 && word_last) state_next = CSUM;
         CSUM: if (rx_end) state_next = (rx_data == csum) ? DONE : ERR;
         default: state_next = IDLE;
      endcase
      if (timeout_hit) state_next = ERR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'd0;
         cpu_hold  <= 1'b1;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
         len_lo    <= 8'd0;
         len       <= 16'd0;
         csum      <= 8'd0;
         byte_idx  <= 2'd0;
         word_idx  <= '0;
         word_buf  <= 24'd0;
         tmr       <= '0;
      end else begin
         mem_we <= 1'b0;
         if (rx_end || !in_frame || timeout_hit) tmr <= '0;
         else                                    tmr <= tmr + TMR_W'(1);

         if (state_next == LEN0 && state != LEN0) begin
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
            cpu_hold  <= 1'b1;
            csum      <= 8'd0;
            byte_idx  <= 2'd0;
            word_idx  <= '0;
         end

         if (rx_end) begin
            if (state == LEN0) len_lo <= rx_data;
            if (state == LEN1) len    <= len_rx;
            if (state == DATA) begin
               csum     <= csum + rx_data;
               byte_idx <= byte_idx + 2'd1;
               case (byte_idx)
                  2'd0: word_buf[7:0]   <= rx_data;
                  2'd1: word_buf[15:8]  <= rx_data;
                  2'd2: word_buf[23:16] <= rx_data;
                  default: begin
                     mem_we    <= 1'b1;
                     mem_addr  <= BASE_ADDR + (ADDR_W'(word_idx) << 2);
                     mem_wdata <= {rx_data, word_buf};
                     word_idx  <= word_idx + WIDX_W'(1);
                  end
               endcase
            end
         end

         if (state_next == DONE && state != DONE) begin
            boot_done <= 1'b1;
            cpu_hold  <= 1'b0;
         end
         if (state_next == ERR && state != ERR) boot_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: byte streams are scored against a frame-level
// parser model (expected writes, write cycles and per-byte status).
module tb_uart_boot_ctrl;
   localparam int MAXW = 1024;
   localparam int TMO  = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_end = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        boot_done;
   logic        boot_err;

   uart_boot_ctrl #(
      .ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_end(rx_end), .rx_data(rx_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_err(boot_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t        got_w[$];
   wr_t        exp_w[$];
   logic [7:0] sb[$];
   int         sc[$];
   logic       got_d[$], got_e[$], got_h[$];
   logic       exp_d[$], exp_e[$];
   logic       m_done = 1'b0;
   logic       m_err  = 1'b0;
   int         checks = 0;
   int         failures = 0;

   always @(negedge clk) if (mem_we === 1'b1) got_w.push_back('{mem_addr, mem_wdata, cyc});

   // one rx_end pulse per byte; sc holds the cycle a write from that byte must appear in
   task automatic send_stream(input int maxgap);
      sc.delete(); got_d.delete(); got_e.delete(); got_h.delete();
      foreach (sb[i]) begin
         @(negedge clk);
         rx_end  = 1'b1;
         rx_data = sb[i];
         sc.push_back(cyc + 1);
         @(negedge clk);
         rx_end = 1'b0;
         got_d.push_back(boot_done);
         got_e.push_back(boot_err);
         got_h.push_back(cpu_hold);
         repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   // frame-level parser: walks the byte list and derives writes and status after each byte
   task automatic model_stream();
      int         i = 0;
      int         n;
      logic [7:0] sum;
      logic [31:0] w;
      exp_w.delete(); exp_d.delete(); exp_e.delete();
      while (i < sb.size()) begin
         if (sb[i] != 8'hA5) begin
            exp_d.push_back(m_done); exp_e.push_back(m_err);
            i++;
         end else begin
            n = {16'd0, sb[i+2], sb[i+1]};
            m_done = 1'b0;
            m_err  = (n > MAXW);
            exp_d.push_back(1'b0); exp_e.push_back(1'b0);
            exp_d.push_back(1'b0); exp_e.push_back(1'b0);
            exp_d.push_back(1'b0); exp_e.push_back(m_err);
            i += 3;
            if (!m_err) begin
               sum = 8'd0;
               for (int k = 0; k < n; k++) begin
                  w   = {sb[i+3], sb[i+2], sb[i+1], sb[i]};
                  sum = sum + sb[i] + sb[i+1] + sb[i+2] + sb[i+3];
                  exp_w.push_back('{32'(4 * k), w, sc[i+3]});
                  repeat (4) begin exp_d.push_back(1'b0); exp_e.push_back(1'b0); end
                  i += 4;
               end
               m_done = (sb[i] == sum);
               m_err  = !m_done;
               exp_d.push_back(m_done); exp_e.push_back(m_err);
               i++;
            end
         end
      end
   endtask

   task automatic add_frame(input int n, input bit bad);
      logic [7:0] s = 8'd0;
      logic [7:0] b;
      sb.push_back(8'hA5); sb.push_back(n[7:0]); sb.push_back(n[15:8]);
      if (n <= MAXW) begin
         for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            s = s + b;
            sb.push_back(b);
         end
         sb.push_back(bad ? s + 8'($urandom_range(255, 1)) : s);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++; if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
      checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 32'h0)  begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      checks++; if (boot_done !== 1'b0)  begin failures++; $display("FAIL reset_boot_done got=%b exp=0", boot_done); end
      checks++; if (boot_err !== 1'b0)   begin failures++; $display("FAIL reset_boot_err got=%b exp=0", boot_err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // directed streams, then scored against the model
   task automatic test_frames();
      for (int c = 0; c < 5; c++) begin
         sb.delete(); got_w.delete();
         case (c)
            0: sb = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
            1: sb = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h41};
            2: sb = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
            3: sb = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
            default: add_frame(MAXW, 1'b0);
         endcase
         send_stream(c == 4 ? 0 : 4);
         model_stream();
         for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_h[i] !== !exp_d[i]) begin
               failures++;
               $display("FAIL frames%0d_status byte=%0d done/err/hold got=%b%b%b exp=%b%b%b",
                        c, i, got_d[i], got_e[i], got_h[i], exp_d[i], exp_e[i], !exp_d[i]);
            end
         end
         checks++;
         if (got_w.size() != exp_w.size()) begin
            failures++;
            $display("FAIL frames%0d_write_count got=%0d exp=%0d", c, got_w.size(), exp_w.size());
         end
         for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i].addr !== exp_w[i].addr || got_w[i].data !== exp_w[i].data || got_w[i].cyc != exp_w[i].cyc) begin
               failures++;
               $display("FAIL frames%0d_write%0d got=%h/%h@%0d exp=%h/%h@%0d", c, i, got_w[i].addr,
                        got_w[i].data, got_w[i].cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         n;
      sb.delete(); got_w.delete();
      for (int f = 0; f < 25; f++) begin
         repeat ($urandom_range(2, 0)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            sb.push_back(b);
         end
         if ($urandom_range(7, 0) == 0) n = MAXW + 1 + $urandom_range(3000, 0);
         else                           n = $urandom_range(5, 0);
         add_frame(n, $urandom_range(3, 0) == 0);
      end
      send_stream(5);
      model_stream();
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_h[i] !== !exp_d[i]) begin
            failures++;
            $display("FAIL random_status byte=%0d done/err/hold got=%b%b%b exp=%b%b%b",
                     i, got_d[i], got_e[i], got_h[i], exp_d[i], exp_e[i], !exp_d[i]);
         end
      end
      checks++;
      if (got_w.size() != exp_w.size()) begin
         failures++;
         $display("FAIL random_write_count got=%0d exp=%0d", got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++;
         if (got_w[i].addr !== exp_w[i].addr || got_w[i].data !== exp_w[i].data || got_w[i].cyc != exp_w[i].cyc) begin
            failures++;
            $display("FAIL random_write%0d got=%h/%h@%0d exp=%h/%h@%0d", i, got_w[i].addr, got_w[i].data,
                     got_w[i].cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
         end
      end
   endtask

   task automatic test_timeout();
      int first = -1;
      int last;
      sb = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      got_w.delete();
      send_stream(3);
      last = sc[4];
      for (int t = 0; t < 300; t++) begin
         if (boot_err === 1'b1) begin first = cyc; break; end
         @(negedge clk);
      end
      checks++;
      if (first != last + TMO) begin
         failures++;
         $display("FAIL timeout_cycle got=%0d exp=%0d", first, last + TMO);
      end
      checks++; if (got_w.size() != 0) begin failures++; $display("FAIL timeout_no_write got=%0d exp=0", got_w.size()); end
      checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL timeout_cpu_hold got=%b exp=1", cpu_hold); end
      checks++; if (boot_done !== 1'b0) begin failures++; $display("FAIL timeout_boot_done got=%b exp=0", boot_done); end
      sb = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
      send_stream(4);
      checks++;
      if (got_w.size() != 1 || got_w[0].addr !== 32'h0 || got_w[0].data !== 32'h44332211) begin
         failures++;
         $display("FAIL timeout_reload_write count=%0d exp one write 0/44332211", got_w.size());
      end
      checks++;
      if (boot_done !== 1'b1 || boot_err !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL timeout_reload_status done/err/hold got=%b%b%b exp=100", boot_done, boot_err, cpu_hold);
      end
   endtask

   task automatic test_reset_mid_frame();
      sb = '{8'hA5, 8'h01, 8'h00, 8'hDD, 8'hCC};
      got_w.delete();
      send_stream(2);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL midrst_cpu_hold got=%b exp=1", cpu_hold); end
      checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL midrst_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 32'h0)  begin failures++; $display("FAIL midrst_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL midrst_mem_wdata got=%h exp=0", mem_wdata); end
      checks++; if (boot_done !== 1'b0)  begin failures++; $display("FAIL midrst_boot_done got=%b exp=0", boot_done); end
      checks++; if (boot_err !== 1'b0)   begin failures++; $display("FAIL midrst_boot_err got=%b exp=0", boot_err); end
      @(negedge clk);
      rst_n = 1'b1;
      sb = '{8'hA5, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h0E};
      send_stream(3);
      checks++;
      if (got_w.size() != 1 || got_w[0].addr !== 32'h0 || got_w[0].data !== 32'hAABBCCDD) begin
         failures++;
         $display("FAIL midrst_reload_write count=%0d exp one write 0/AABBCCDD", got_w.size());
      end
      checks++;
      if (boot_done !== 1'b1 || boot_err !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL midrst_reload_status done/err/hold got=%b%b%b exp=100", boot_done, boot_err, cpu_hold);
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_random();
      test_timeout();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
